// File: rtl/dmem_responder.sv
// Single-port data-memory responder with a fixed request-to-response latency.
// Accepts one load/store at a time, checks alignment/range, and holds the response until it is taken.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    input  logic [2:0]  ReqSize,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateType;

    stateType        state;
    stateType        nextState;
    logic [3:0]      count;
    logic            capWrite;
    logic [31:0]     capAddr;
    logic [31:0]     capWData;
    logic [2:0]      capSize;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            enterResp;
    logic            fault;
    logic [AW-1:0]   wordIdx;
    logic [1:0]      lane;
    logic [31:0]     rdWord;
    logic [7:0]      rdByte;
    logic [15:0]     rdHalf;
    logic [31:0]     loadData;
    logic [31:0]     wrData;
    logic [3:0]      byteEn;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept)          nextState = WAIT;
            WAIT:    if (count == 4'd1)   nextState = RESP;
            RESP:    if (RespReady)       nextState = IDLE;
            default:                      nextState = IDLE;
        endcase
    end

    always_comb begin
        ReqReady  = (state == IDLE) && !reset;
        RespValid = (state == RESP);
    end

    assign accept    = ReqValid && ReqReady;
    assign enterResp = (state == WAIT) && (count == 4'd1) && !reset;

    // Request fields are held for the whole transaction; nothing outside the accept edge is looked at.
    always_ff @(posedge clk) begin
        if (accept) begin
            capWrite <= ReqWrite;
            capAddr  <= ReqAddr;
            capWData <= ReqWData;
            capSize  <= ReqSize;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= 4'd0;
            RespRData <= 32'd0;
            RespErr   <= 1'b0;
        end else begin
            if (accept) begin
                count <= 4'(LATENCY);
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (enterResp) begin
                RespErr   <= fault;
                RespRData <= (fault || capWrite) ? 32'd0 : loadData;
            end
        end
    end

    always_comb begin
        fault = (capAddr[31:AW+2] != '0);
        case (capSize)
            3'b000:  fault = fault;
            3'b100:  fault = fault | capWrite;
            3'b001:  fault = fault | capAddr[0];
            3'b101:  fault = fault | capAddr[0] | capWrite;
            3'b010:  fault = fault | (capAddr[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
    end

    always_comb begin
        wordIdx = capAddr[AW+1:2];
        lane    = capAddr[1:0];
        rdWord  = mem[wordIdx];
        rdByte  = rdWord[{lane, 3'b000} +: 8];
        rdHalf  = capAddr[1] ? rdWord[31:16] : rdWord[15:0];
        case (capSize)
            3'b000:  loadData = {{24{rdByte[7]}}, rdByte};
            3'b100:  loadData = {24'd0, rdByte};
            3'b001:  loadData = {{16{rdHalf[15]}}, rdHalf};
            3'b101:  loadData = {16'd0, rdHalf};
            default: loadData = rdWord;
        endcase
    end

    // Store data is replicated across lanes so each enabled lane simply takes its own slice.
    always_comb begin
        case (capSize)
            3'b000: begin
                byteEn = 4'b0001 << lane;
                wrData = {4{capWData[7:0]}};
            end
            3'b001: begin
                byteEn = capAddr[1] ? 4'b1100 : 4'b0011;
                wrData = {2{capWData[15:0]}};
            end
            default: begin
                byteEn = 4'b1111;
                wrData = capWData;
            end
        endcase
    end

    // Commit happens only on the edge entering RESP, so a reset in WAIT drops the store.
    always_ff @(posedge clk) begin
        if (enterResp && capWrite && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][i*8 +: 8] <= wrData[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table of load/store vectors through a scoreboard,
// plus hand-written response-stall and reset-during-wait sequences.
module tb_dmem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [31:0] ReqAddr = 32'd0;
    logic [31:0] ReqWData = 32'd0;
    logic [2:0]  ReqSize = 3'd0;
    logic        RespValid;
    logic        RespReady = 1'b1;
    logic [31:0] RespRData;
    logic        RespErr;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .ReqSize   (ReqSize),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespRData (RespRData),
        .RespErr   (RespErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] expData;
        logic        expErr;
    } vecT;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          acceptCycle;
    } expT;

    vecT  vecs[$];
    expT  sb[$];
    expT  popped;
    vecT  v;
    int   cycle = 0;
    int   checks = 0;
    int   failures = 0;
    logic inResp = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic [31:0] expData, input logic expErr);
        vecT t;
        t.write = write; t.addr = addr; t.wdata = wdata; t.size = size;
        t.expData = expData; t.expErr = expErr;
        vecs.push_back(t);
    endtask

    // Drives one request, pushes its expected response, and optionally waits for it to drain.
    task automatic applyStimulus(input vecT s, input bit waitDone);
        int  n;
        expT e;
        @(negedge clk);
        ReqValid = 1'b1;
        ReqWrite = s.write;
        ReqAddr  = s.addr;
        ReqWData = s.wdata;
        ReqSize  = s.size;
        n = 0;
        while (!ReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ReqReady) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout: ReqReady got 0 expected 1 within 100 cycles");
            ReqValid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.data = s.expData;
        e.err = s.expErr;
        e.acceptCycle = cycle;
        sb.push_back(e);
        ReqValid = 1'b0;
        ReqWrite = 1'($urandom);
        ReqAddr  = $urandom;
        ReqWData = $urandom;
        ReqSize  = 3'($urandom);
        checkOutput("readyAfterAccept", 32'(ReqReady), 32'd0);
        if (waitDone) begin
            n = 0;
            while (sb.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (sb.size() != 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL respTimeout: pending got %0d expected 0", sb.size());
                sb.delete();
            end
        end
    endtask

    // Scoreboard side: latency measured at the first valid cycle, data compared at the handshake.
    always @(negedge clk) begin
        if (!reset && RespValid) begin
            if (sb.size() == 0) begin
                if (!inResp) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpectedResp: RespValid got 1 expected 0");
                end
                inResp = !RespReady;
            end else begin
                if (!inResp) begin
                    inResp = 1'b1;
                    checkOutput("latency", 32'(cycle - sb[0].acceptCycle), 32'(LATENCY));
                end
                if (RespReady) begin
                    popped = sb.pop_front();
                    checkOutput("rdata", RespRData, popped.data);
                    checkOutput("err", 32'(RespErr), 32'(popped.err));
                    inResp = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        addVec(1, 32'h0000_0000, 32'h1111_2222, SZ_W,  32'h0000_0000, 0);
        addVec(1, 32'h0000_0010, 32'hDEAD_BEEF, SZ_W,  32'h0000_0000, 0);
        addVec(0, 32'h0000_0010, 32'h0,         SZ_W,  32'hDEAD_BEEF, 0);
        addVec(0, 32'h0000_0013, 32'h0,         SZ_B,  32'hFFFF_FFDE, 0);
        addVec(0, 32'h0000_0013, 32'h0,         SZ_BU, 32'h0000_00DE, 0);
        addVec(0, 32'h0000_0010, 32'h0,         SZ_H,  32'hFFFF_BEEF, 0);
        addVec(0, 32'h0000_0012, 32'h0,         SZ_HU, 32'h0000_DEAD, 0);
        addVec(1, 32'h0000_0011, 32'h0000_00AA, SZ_B,  32'h0000_0000, 0);
        addVec(0, 32'h0000_0010, 32'h0,         SZ_W,  32'hDEAD_AAEF, 0);
        addVec(0, 32'h0000_0012, 32'h0,         SZ_W,  32'h0000_0000, 1);
        addVec(0, 32'h0000_0011, 32'h0,         SZ_H,  32'h0000_0000, 1);
        addVec(1, 32'h0000_0400, 32'h5555_5555, SZ_W,  32'h0000_0000, 1);
        addVec(0, 32'h0000_0010, 32'h0,         3'b011, 32'h0000_0000, 1);
        addVec(1, 32'h0000_0010, 32'h0000_0077, SZ_BU, 32'h0000_0000, 1);
        addVec(1, 32'h0000_0010, 32'h0000_7777, SZ_HU, 32'h0000_0000, 1);
        addVec(1, 32'h0000_0010, 32'h0000_0066, 3'b110, 32'h0000_0000, 1);
        addVec(0, 32'h0000_0010, 32'h0,         SZ_W,  32'hDEAD_AAEF, 0);
        addVec(0, 32'h0000_0000, 32'h0,         SZ_W,  32'h1111_2222, 0);
        addVec(1, 32'h0000_0002, 32'hFFFF_8001, SZ_H,  32'h0000_0000, 0);
        addVec(0, 32'h0000_0002, 32'h0,         SZ_H,  32'hFFFF_8001, 0);
        addVec(0, 32'h0000_0000, 32'h0,         SZ_HU, 32'h0000_2222, 0);
        addVec(0, 32'h0000_0003, 32'h0,         SZ_B,  32'hFFFF_FF80, 0);
        addVec(0, 32'h0000_0000, 32'h0,         SZ_B,  32'h0000_0022, 0);
        addVec(1, 32'h0000_03FC, 32'hA5A5_A5A5, SZ_W,  32'h0000_0000, 0);
        addVec(0, 32'h0000_03FC, 32'h0,         SZ_W,  32'hA5A5_A5A5, 0);
        addVec(0, 32'h0000_03FF, 32'h0,         SZ_BU, 32'h0000_00A5, 0);
        addVec(0, 32'h0000_03FF, 32'h0,         SZ_W,  32'h0000_0000, 1);
        addVec(0, 32'h0000_0400, 32'h0,         SZ_B,  32'h0000_0000, 1);
        addVec(0, 32'h0000_0000, 32'h0,         SZ_W,  32'h8001_2222, 0);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstRespValid", 32'(RespValid), 32'd0);
        checkOutput("rstRData", RespRData, 32'd0);
        checkOutput("rstErr", 32'(RespErr), 32'd0);
        checkOutput("rstReqReady", 32'(ReqReady), 32'd0);
        reset = 1'b0;

        // Idle with ReqValid low: nothing should move.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("idleReady", 32'(ReqReady), 32'd1);
            checkOutput("idleRespValid", 32'(RespValid), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 1'b1);
        end

        // Response stall: hold RespReady low while in RESP.
        @(posedge clk);
        #1;
        RespReady = 1'b0;
        v.write = 1'b0; v.addr = 32'h10; v.wdata = 32'h0; v.size = SZ_W;
        v.expData = 32'hDEAD_AAEF; v.expErr = 1'b0;
        applyStimulus(v, 1'b0);
        for (int n = 0; n < 20 && !RespValid; n++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stallValid", 32'(RespValid), 32'd1);
            checkOutput("stallData", RespRData, 32'hDEAD_AAEF);
            checkOutput("stallReady", 32'(ReqReady), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        RespReady = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseValid", 32'(RespValid), 32'd0);
        checkOutput("releaseReady", 32'(ReqReady), 32'd1);
        checkOutput("releaseDrained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Reset during WAIT of a store must drop it.
        v.write = 1'b1; v.addr = 32'h20; v.wdata = 32'hCAFE_F00D; v.size = SZ_W;
        v.expData = 32'h0; v.expErr = 1'b0;
        applyStimulus(v, 1'b1);
        v.wdata = 32'h1234_5678;
        applyStimulus(v, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("rstWaitReady", 32'(ReqReady), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rstWaitValid", 32'(RespValid), 32'd0);
        sb.delete();
        inResp = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("afterRstValid", 32'(RespValid), 32'd0);
        end
        v.write = 1'b0; v.addr = 32'h20; v.wdata = 32'h0; v.size = SZ_W;
        v.expData = 32'hCAFE_F00D; v.expErr = 1'b0;
        applyStimulus(v, 1'b1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
